// File: rtl/pixel_packer.sv
// Packs narrow pixel symbols into bus-width words, lane 0 in the LSBs.
// An end-of-frame symbol flushes a partial word with pad lanes and tags it last.
module pixel_packer #(
  parameter int                    unpacked_p   = 2,
  parameter int                    num_packed_p = 4,
  parameter int                    bus_width_p  = unpacked_p * num_packed_p,
  parameter logic [unpacked_p-1:0] pad_p        = '0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [unpacked_p-1:0]  unpacked_i,
  input  logic                   last_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [bus_width_p-1:0] packed_o,
  output logic                   last_o,
  output logic                   valid_o,
  input  logic                   ready_i
);

  localparam int cnt_w = $clog2(num_packed_p);

  logic [bus_width_p-1:0] acc_q, acc_d;
  logic [cnt_w-1:0]       cnt_q, cnt_d;
  logic [bus_width_p-1:0] out_q, out_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;

  logic                   in_fire, out_fire, completing;
  logic [bus_width_p-1:0] ins_word, flush_word;

  assign ready_o  = ~out_valid_q | ready_i;
  assign valid_o  = out_valid_q;
  assign packed_o = out_q;
  assign last_o   = out_last_q;

  assign in_fire    = valid_i & ready_o;
  assign out_fire   = out_valid_q & ready_i;
  assign completing = in_fire & (last_i | (cnt_q == cnt_w'(num_packed_p - 1)));

  // ins_word continues the partial word; flush_word is the same with pad in
  // every lane above the current one. Lanes above cnt_q in acc_q are always 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    ins_word   = acc_q;
    flush_word = acc_q;
    for (int k = 0; k < num_packed_p; k++) begin
      if (cnt_w'(k) == cnt_q) begin
        ins_word[k*unpacked_p +: unpacked_p]   = unpacked_i;
        flush_word[k*unpacked_p +: unpacked_p] = unpacked_i;
      end else if (cnt_w'(k) > cnt_q) begin
        flush_word[k*unpacked_p +: unpacked_p] = pad_p;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    // A completing beat overrides the drain above, so a simultaneous
    // consume-and-load keeps valid_o high with no bubble.
    if (completing) begin
      out_d       = flush_word;
      out_last_d  = last_i;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      acc_d       = '0;
    end else if (in_fire) begin
      acc_d = ins_word;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/pixel_packer.md
# pixel_packer

Packs a stream of narrow pixel symbols (default 2-bit) into bus-width words (default 8-bit bytes) for the UART transmit path. It is the inverse neighbour of the receive-side unpacker: processed pixels come in one symbol per handshake and leave as bytes, with lane ordering chosen so that the unpacker reproduces the original symbol order. An end-of-frame marker flushes a partially filled byte, pads the unused lanes, and tags the byte as last.

## Interface
- unpacked_p, 2: bits per input symbol.
- num_packed_p, 4: symbols per output word; power of two, ≥2.
- bus_width_p, unpacked_p*num_packed_p: output word width.
- pad_p, '0: unpacked_p-bit value written into unfilled lanes on a partial flush.
- clk_i  in  1  single clock; all state is updated on the rising edge.
- reset_i  in  1  asynchronous, active-low reset (0 = in reset).
- unpacked_i  in  unpacked_p  input symbol.
- last_i  in  1  marks the final symbol of a frame; qualified by valid_i.
- valid_i  in  1  input valid.
- ready_o  out  1  input ready.
- packed_o  out  bus_width_p  packed word.
- last_o  out  1  the word on packed_o closes a frame.
- valid_o  out  1  output valid.
- ready_i  in  1  downstream ready.

## Operation
- Input fire: in_fire = valid_i & ready_o. Output fire: out_fire = valid_o & ready_i.
- State:
  - accumulator acc_r (bus_width_p bits)
  - lane counter cnt_r ($clog2(num_packed_p) bits, range 0..num_packed_p-1)
  - output register out_r, out_last_r, out_valid_r
- Lane mapping: the symbol accepted at cnt_r = k occupies bits [k*unpacked_p +: unpacked_p].
  - Lane 0 is the LSBs. This matches the unpacker, which emits bits [1:0] first.
- Completing beat: an in_fire with cnt_r == num_packed_p-1, or any in_fire with last_i = 1.
- Non-completing in_fire:
  - write the symbol into lane cnt_r of acc_r;
  - cnt_r <= cnt_r + 1.
- Completing in_fire:
  - out_r <= acc_r with lane cnt_r = unpacked_i, and lanes above cnt_r = pad_p;
  - out_last_r <= last_i; out_valid_r <= 1;
  - cnt_r <= 0; acc_r <= 0.
- Stale lanes below cnt_r from a previous word must never leak: acc_r is cleared on every completion.
- out_fire with no completing beat in the same cycle: out_valid_r <= 0, out_last_r <= 0. out_r holds its value.
- Handshake:
  - ready_o = ~out_valid_r | ready_i.
  - Input is accepted whenever the output register is empty or draining this cycle.
  - valid_o = out_valid_r; packed_o = out_r; last_o = out_last_r.
- Boundary conditions:
  - last_i on the first symbol of a word: one word is emitted, with lane 0 = data and all other lanes = pad_p.
  - last_i at cnt_r == num_packed_p-1: a full word is emitted with last_o = 1; no pad lanes.
  - out_fire and completing beat in the same cycle: the new word is loaded and valid_o stays 1. No bubble.
  - valid_o may not drop, and packed_o/last_o may not change, while valid_o & ~ready_i.
  - cnt_r wraps num_packed_p-1 → 0 only via a completing beat.

## Timing
- Reset (reset_i = 0, asynchronous assert, synchronous-safe deassert):
  - acc_r, cnt_r, out_r, out_last_r, out_valid_r all clear to 0;
  - hence valid_o = 0, packed_o = 0, last_o = 0, ready_o = 1.
- Reset mid-word discards the partial word silently. Reset while valid_o = 1 drops the pending word.
- Latency: valid_o rises on the clock edge of the completing in_fire. The word is visible one cycle after its final symbol is accepted.
- Throughput: with ready_i held at 1, ready_o stays 1, so one symbol is accepted per cycle and one word is emitted every num_packed_p cycles.
- ready_o has a combinational path from ready_i only. There is no combinational path from valid_i or last_i to any output.

## Test plan
- Full word: symbols 1, 2, 3, 0 on consecutive cycles, last_i = 0, ready_i = 1 → one cycle after the 4th beat, packed_o = 0x39, valid_o = 1, last_o = 0.
- Partial flush: symbols 3, 1 with last_i = 1 on the second, pad_p = 0 → packed_o = 0x07, last_o = 1. The next frame's symbols 2, 2, 2, 2 → 0xAA with last_o = 0.
- Backpressure:
  - Stimulus: ready_i = 0 after the 0x39 word is loaded; valid_i held at 1.
  - Required: ready_o = 0, and packed_o/valid_o stay stable for 10 cycles.
  - Release ready_i: the word is consumed, and the next 4 symbols 0, 0, 0, 3 produce 0xC0 with no lost or duplicated symbols.
- Streaming: 16 back-to-back symbols (0..3 repeating), ready_i = 1 → ready_o never drops; exactly four 0xE4 words, each at 4-cycle spacing.
- Reset mid-word: accept symbols 3, 3, pulse reset_i low for 1 cycle (not clock aligned), then send 0, 0, 0, 3 → outputs at 0 during reset; single word 0xC0.
- Round trip: 256 random symbols with random valid_i/ready_i stalls → feeding packed_o into the unpacker reproduces the input sequence exactly.
